sdrv_covox_dac: RTL and testbench
=================================

Name: sdrv_covox_dac

Overview:
- Audio back-end fed directly by the I/O port decoder's `covox_stb` / `sdrv_stb` strobes.
- Latches the 8-bit Covox sample and the four Soundrive channel samples from the Z80 write bus.
- Mixes them into left and right sums through a registered pipeline.
- Drives two first-order sigma-delta 1-bit DAC pins to the board's RC output filters.

Parameters:
- MOD_DIV, 1, number of clk cycles per modulator step (1 = every clk); must be >= 1.
- RST_LEVEL, 8'h80, reset value of every sample register (unsigned mid-scale silence).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr_lo  in  8  low byte of the I/O address (port number)
- data_in  in  8  Z80 write data
- covox_stb  in  1  write strobe for port FB, from the decoder
- sdrv_stb  in  1  write strobe for Soundrive ports 0F/1F/4F/5F, from the decoder
- dac_l  out  1  left sigma-delta bitstream
- dac_r  out  1  right sigma-delta bitstream
- mod_tick  out  1  one-cycle pulse on each modulator step (for test/monitoring)

Behaviour:
- Reset and clocking:
  - One clock domain (clk); reset is synchronous and active-high.
  - On reset: cvx, ch_a, ch_b, ch_c, ch_d = RST_LEVEL; sum_l, sum_r = 0; acc_l, acc_r = 0; div counter = 0; dac_l, dac_r, mod_tick = 0.
- Sample capture:
  - Evaluated every clk where the strobe is high; a multi-cycle strobe rewrites the same value, which is harmless.
  - covox_stb=1: cvx <= data_in; addr_lo is ignored.
  - sdrv_stb=1 with addr_lo 0F -> ch_a, 1F -> ch_b, 4F -> ch_c, 5F -> ch_d.
  - sdrv_stb=1 with any other addr_lo: no register changes.
  - covox_stb and sdrv_stb high in the same cycle: both writes take effect independently.
- Mixer stage, registered every clk, not gated by the modulator step:
  - sum_l <= ch_a + ch_b + cvx; sum_r <= ch_c + ch_d + cvx.
  - Unsigned, 10-bit results; maximum 765, no saturation needed.
  - Latency from a strobe in cycle N: sample register updated at N+1, sum at N+2.
- Step divider:
  - Counter runs 0..MOD_DIV-1 and wraps to 0.
  - mod_tick = 1 in the cycle the counter equals MOD_DIV-1.
  - With MOD_DIV=1, mod_tick is high every cycle after reset deasserts.
- Modulator, updates on the clk edge where mod_tick=1; otherwise holds:
  - acc_x is 11 bits: acc_x <= {1'b0, acc_x[9:0]} + sum_x, then dac_x <= carry of that addition (bit 10 of the new acc_x).
  - Long-run ones density on dac_x = sum_x/1024 per modulator step.
  - Full-scale 765 gives density 765/1024; sum 0 gives a constant 0.
- Outputs: dac_l, dac_r and mod_tick are registered with no combinational path from the inputs.
- Reset mid-operation: every register returns to its reset value on the next edge.
  - The first modulator step after reset uses sum = 0 if it happens before the mixer reloads.
  - After two clk cycles the sums reflect RST_LEVEL (3*0x80 = 384).
- No read-back: this block never drives the data bus, and the decoder does not report these ports as readable.

Test Plan:
1. Reset (MOD_DIV=1), no writes:
   - During reset: dac_l = dac_r = 0.
   - Two cycles after reset: sum_l = sum_r = 384.
   - Over 1024 steps: exactly 384 ones on each output.
2. Write FB=0x00, 0F=0xFF, 1F=0x01, one-cycle strobes:
   - Each sample register updates one cycle after its strobe.
   - sum_l = 256 two cycles after the last strobe.
   - Over the next 8 steps dac_l is 1 exactly twice (density 1/4).
3. sdrv_stb with addr_lo=2F, data 0x00:
   - All channel registers unchanged; sum_l and sum_r unchanged.
4. Write FB=0x00, 0F=0x00, 1F=0x00; then 4F=0xFF, 5F=0xFF, FB=0xFF:
   - dac_l stays constant 0.
   - sum_r = 765; dac_r has 765 ones per 1024 steps.
5. MOD_DIV=4:
   - mod_tick pulses every 4th cycle.
   - acc and dac change only on tick edges; dac holds between ticks.
6. Assert rst while dac_r=1 and acc is nonzero:
   - Next edge: dac_r = 0, acc = 0, all samples = 0x80, counter = 0.

Source files
------------

// File: rtl/sdrv_covox_dac_if.sv
// Write-side bus from the I/O port decoder into the Covox/Soundrive DAC block.
// The master drives the port number, the write data and the two decoded strobes.
interface sdrv_covox_dac_if;
    logic [7:0] addr_lo;
    logic [7:0] data_in;
    logic       covox_stb;
    logic       sdrv_stb;

    modport master (
        output addr_lo,
        output data_in,
        output covox_stb,
        output sdrv_stb
    );

    modport slave (
        input addr_lo,
        input data_in,
        input covox_stb,
        input sdrv_stb
    );
endinterface

// File: rtl/sdrv_covox_dac.sv
// Covox + Soundrive sample latches, registered L/R mixer and two first-order
// sigma-delta 1-bit DACs stepped by a programmable clock divider.
module sdrv_covox_dac #(
    parameter int unsigned MOD_DIV   = 1,
    parameter logic [7:0]  RST_LEVEL = 8'h80
) (
    input  logic                clk,
    input  logic                rst,
    sdrv_covox_dac_if.slave     bus,
    output logic                dac_l,
    output logic                dac_r,
    output logic                mod_tick
);
    localparam int unsigned DivW = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(MOD_DIV - 1);

    logic [7:0]      cvx_q, cvx_d;
    logic [7:0]      ch_a_q, ch_a_d;
    logic [7:0]      ch_b_q, ch_b_d;
    logic [7:0]      ch_c_q, ch_c_d;
    logic [7:0]      ch_d_q, ch_d_d;
    logic [9:0]      sum_l_q, sum_l_d;
    logic [9:0]      sum_r_q, sum_r_d;
    logic [10:0]     acc_l_q, acc_l_d;
    logic [10:0]     acc_r_q, acc_r_d;
    logic [DivW-1:0] div_q, div_d;
    logic            dac_l_q, dac_l_d;
    logic            dac_r_q, dac_r_d;
    logic            mod_tick_q, mod_tick_d;

    always_comb begin
        cvx_d      = cvx_q;
        ch_a_d     = ch_a_q;
        ch_b_d     = ch_b_q;
        ch_c_d     = ch_c_q;
        ch_d_d     = ch_d_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        dac_l_d    = dac_l_q;
        dac_r_d    = dac_r_q;

        if (bus.covox_stb) begin
            cvx_d = bus.data_in;
        end
        if (bus.sdrv_stb) begin
            case (bus.addr_lo)
                8'h0F:   ch_a_d = bus.data_in;
                8'h1F:   ch_b_d = bus.data_in;
                8'h4F:   ch_c_d = bus.data_in;
                8'h5F:   ch_d_d = bus.data_in;
                default: ;
            endcase
        end

        // Mixer runs every clk; the modulator samples whatever sum is current.
        sum_l_d = 10'(ch_a_q) + 10'(ch_b_q) + 10'(cvx_q);
        sum_r_d = 10'(ch_c_q) + 10'(ch_d_q) + 10'(cvx_q);

        div_d      = (div_q == DivLast) ? '0 : div_q + 1'b1;
        mod_tick_d = (div_d == DivLast);

        // Carry out of the 10-bit accumulator is the output bit.
        if (mod_tick_q) begin
            acc_l_d = {1'b0, acc_l_q[9:0]} + {1'b0, sum_l_q};
            acc_r_d = {1'b0, acc_r_q[9:0]} + {1'b0, sum_r_q};
            dac_l_d = acc_l_d[10];
            dac_r_d = acc_r_d[10];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cvx_q      <= RST_LEVEL;
            ch_a_q     <= RST_LEVEL;
            ch_b_q     <= RST_LEVEL;
            ch_c_q     <= RST_LEVEL;
            ch_d_q     <= RST_LEVEL;
            sum_l_q    <= '0;
            sum_r_q    <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            div_q      <= '0;
            dac_l_q    <= 1'b0;
            dac_r_q    <= 1'b0;
            mod_tick_q <= 1'b0;
        end else begin
            cvx_q      <= cvx_d;
            ch_a_q     <= ch_a_d;
            ch_b_q     <= ch_b_d;
            ch_c_q     <= ch_c_d;
            ch_d_q     <= ch_d_d;
            sum_l_q    <= sum_l_d;
            sum_r_q    <= sum_r_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            div_q      <= div_d;
            dac_l_q    <= dac_l_d;
            dac_r_q    <= dac_r_d;
            mod_tick_q <= mod_tick_d;
        end
    end

    assign dac_l    = dac_l_q;
    assign dac_r    = dac_r_q;
    assign mod_tick = mod_tick_q;
endmodule

// File: tb/tb_sdrv_covox_dac.sv
// Scoreboard bench: two instances (step every clk and every 4th clk) share one
// write bus; a sample-level model predicts each cycle's outputs.
module tb_sdrv_covox_dac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdrv_covox_dac_if bus ();

    logic dac_l0, dac_r0, tick0;
    logic dac_l1, dac_r1, tick1;

    sdrv_covox_dac #(.MOD_DIV(1), .RST_LEVEL(8'h80)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus), .dac_l(dac_l0), .dac_r(dac_r0), .mod_tick(tick0)
    );
    sdrv_covox_dac #(.MOD_DIV(4), .RST_LEVEL(8'h80)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus), .dac_l(dac_l1), .dac_r(dac_r1), .mod_tick(tick1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples index 0=covox, 1..4 = channels A..D.
    int          divs [2] = '{1, 4};
    int          m_smp[2][5];
    int          m_sum_l[2], m_sum_r[2], m_acc_l[2], m_acc_r[2], m_cnt[2];
    bit          m_tick[2], m_dl[2], m_dr[2];
    logic [2:0]  exp_q0[$];
    logic [2:0]  exp_q1[$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 5; k++) m_smp[i][k] = 128;
                m_sum_l[i] = 0; m_sum_r[i] = 0; m_acc_l[i] = 0; m_acc_r[i] = 0;
                m_cnt[i] = 0; m_tick[i] = 0; m_dl[i] = 0; m_dr[i] = 0;
            end else begin
                if (m_tick[i]) begin
                    m_acc_l[i] = m_acc_l[i] % 1024 + m_sum_l[i];
                    m_acc_r[i] = m_acc_r[i] % 1024 + m_sum_r[i];
                    m_dl[i] = (m_acc_l[i] >= 1024);
                    m_dr[i] = (m_acc_r[i] >= 1024);
                end
                m_cnt[i]  = (m_cnt[i] + 1) % divs[i];
                m_tick[i] = (m_cnt[i] == divs[i] - 1);
                m_sum_l[i] = m_smp[i][0] + m_smp[i][1] + m_smp[i][2];
                m_sum_r[i] = m_smp[i][0] + m_smp[i][3] + m_smp[i][4];
                if (bus.covox_stb) m_smp[i][0] = int'(bus.data_in);
                if (bus.sdrv_stb) begin
                    if (bus.addr_lo == 8'h0F) m_smp[i][1] = int'(bus.data_in);
                    if (bus.addr_lo == 8'h1F) m_smp[i][2] = int'(bus.data_in);
                    if (bus.addr_lo == 8'h4F) m_smp[i][3] = int'(bus.data_in);
                    if (bus.addr_lo == 8'h5F) m_smp[i][4] = int'(bus.data_in);
                end
            end
        end
        exp_q0.push_back({m_dl[0], m_dr[0], m_tick[0]});
        exp_q1.push_back({m_dl[1], m_dr[1], m_tick[1]});
    end

    // Monitor: outputs are valid every cycle, so one expectation is popped per cycle.
    bit mon_en = 1'b0;
    initial begin
        @(posedge clk);
        mon_en = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                chk("sb_dut0_dl_dr_tick", {29'd0, dac_l0, dac_r0, tick0}, {29'd0, exp_q0.pop_front()});
                chk("sb_dut1_dl_dr_tick", {29'd0, dac_l1, dac_r1, tick1}, {29'd0, exp_q1.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit is_cvx, input logic [7:0] addr, input logic [7:0] data);
        bus.addr_lo   = addr;
        bus.data_in   = data;
        bus.covox_stb = is_cvx;
        bus.sdrv_stb  = !is_cvx;
        cyc();
        bus.covox_stb = 1'b0;
        bus.sdrv_stb  = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            ones_l += int'(dac_l0);
            ones_r += int'(dac_r0);
        end
    endtask

    initial begin
        int ol, or_, ticks, bad, waited;
        logic prev_tick, prev_dl;
        bus.addr_lo = 8'h00; bus.data_in = 8'h00; bus.covox_stb = 1'b0; bus.sdrv_stb = 1'b0;

        // 1: reset, then mid-scale silence gives density 384/1024.
        repeat (3) cyc();
        chk("rst_dac_l", {31'd0, dac_l0}, 32'd0);
        chk("rst_dac_r", {31'd0, dac_r0}, 32'd0);
        chk("rst_tick", {31'd0, tick0}, 32'd0);
        rst = 1'b0;
        cyc();
        count_ones(1024, ol, or_);
        chk("idle_density_l", ol, 384);
        chk("idle_density_r", or_, 384);

        // 2: sum_l = 0 + 255 + 1 = 256 -> 2 ones per 8 steps.
        wr(1'b1, 8'hFB, 8'h00);
        wr(1'b0, 8'h0F, 8'hFF);
        wr(1'b0, 8'h1F, 8'h01);
        repeat (3) cyc();
        count_ones(8, ol, or_);
        chk("quarter_density_l", ol, 2);

        // 3: unmapped Soundrive port must not disturb anything.
        wr(1'b0, 8'h2F, 8'h00);
        repeat (3) cyc();
        count_ones(8, ol, or_);
        chk("unmapped_port_l", ol, 2);

        // 4: left silent, then right at full scale 765.
        wr(1'b1, 8'hFB, 8'h00);
        wr(1'b0, 8'h0F, 8'h00);
        wr(1'b0, 8'h1F, 8'h00);
        repeat (3) cyc();
        count_ones(16, ol, or_);
        chk("zero_sum_l", ol, 0);
        wr(1'b0, 8'h4F, 8'hFF);
        wr(1'b0, 8'h5F, 8'hFF);
        wr(1'b1, 8'hFB, 8'hFF);
        repeat (3) cyc();
        count_ones(1024, ol, or_);
        chk("full_scale_r", or_, 765);

        // 5: divided instance ticks every 4th cycle and only moves dac on tick edges.
        ticks = 0; bad = 0;
        prev_tick = tick1; prev_dl = dac_l1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            ticks += int'(tick1);
            if (dac_l1 !== prev_dl && !prev_tick) bad++;
            prev_tick = tick1; prev_dl = dac_l1;
        end
        chk("div4_tick_count", ticks, 10);
        chk("div4_dac_hold", bad, 0);

        // 6: reset while dac_r is high.
        waited = 0;
        while (dac_r0 !== 1'b1 && waited < 64) begin
            cyc();
            waited++;
        end
        chk("wait_dac_r_high", {31'd0, dac_r0}, 32'd1);
        rst = 1'b1;
        cyc();
        chk("midrst_dac_r", {31'd0, dac_r0}, 32'd0);
        chk("midrst_tick", {31'd0, tick0}, 32'd0);
        rst = 1'b0;
        cyc();
        count_ones(1024, ol, or_);
        chk("post_rst_density_l", ol, 384);
        chk("post_rst_density_r", or_, 384);

        // Random traffic, including simultaneous and held strobes.
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 4))
                0: bus.addr_lo = 8'h0F;
                1: bus.addr_lo = 8'h1F;
                2: bus.addr_lo = 8'h4F;
                3: bus.addr_lo = 8'h5F;
                default: bus.addr_lo = 8'($urandom);
            endcase
            bus.data_in   = 8'($urandom);
            bus.covox_stb = ($urandom_range(0, 3) == 0);
            bus.sdrv_stb  = ($urandom_range(0, 2) == 0);
            cyc();
        end
        bus.covox_stb = 1'b0;
        bus.sdrv_stb  = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
